serial_output_fifo: RTL and testbench

Parametrised successor to the CPU debug UART transmitter. It accepts words from the control CPU over the stb/ack stream handshake and buffers them in an internal FIFO. It serialises them onto `tx` with configurable data width, parity and stop bits, and gates each frame start with CTS flow control. It sits between `main_0`'s debug output stream and the board RS-232 pin. Unlike the fixed 8N1 unbuffered transmitter, it absorbs CPU bursts without stalling the CPU.

---
 rtl/serial_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/serial_output_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_serial_output_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types, constants and helpers for the serial transmitter
// Contents:
//   tx_state_t   : transmitter FSM states
//   PARITY_*     : parity mode encodings for the parity parameter
//   baud_divisor : clock cycles per bit, truncated

package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int baud_divisor(input int clk_hz, input int baud_hz);
    return clk_hz / baud_hz;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered ready and occupancy output
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_tdata/in_tvalid/in_tready : write side; transfer when valid && ready
//   out_tdata/out_tvalid        : head word (show-ahead) and non-empty flag
//   out_tready                  : pop the head word this cycle
//   count                       : current occupancy, 0..DEPTH

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [WIDTH-1:0] out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic [CW-1:0]    count
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count_next;

  assign out_tvalid = (count != '0);
  assign out_tdata  = mem[rd_ptr];
  assign push       = in_tvalid && in_tready;
  assign pop        = out_tready && out_tvalid;
  assign count_next = count + CW'(push) - CW'(pop);

  // Ready is registered from the next occupancy so it drops on the same edge
  // that fills the last free slot, and stays low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_tready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      in_tready <= (count_next < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_tdata;
  end

endmodule

// File: rtl/serial_output_fifo.sv
// rtl/serial_output_fifo.sv - buffered UART transmitter with CTS-gated frame start
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   in1/in1_stb/in1_ack : word input stream; transfer when stb && ack
//   cts                : asynchronous clear-to-send, sampled only between frames
//   tx                 : serial line, idle high, registered
//   busy               : frame in progress or words still buffered
//   fill_level         : current FIFO occupancy

module serial_output_fifo
  import serial_pkg::*;
#(
  parameter int clock_frequency = 50000000,
  parameter int baud_rate       = 2000000,
  parameter int data_bits       = 8,
  parameter int parity          = 0,
  parameter int stop_bits       = 1,
  parameter int fifo_depth      = 16,
  localparam int FILL_W = $clog2(fifo_depth) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [data_bits-1:0] in1,
  input  logic                 in1_stb,
  output logic                 in1_ack,
  input  logic                 cts,
  output logic                 tx,
  output logic                 busy,
  output logic [FILL_W-1:0]    fill_level
);

  localparam int D      = baud_divisor(clock_frequency, baud_rate);
  localparam int BAUD_W = $clog2(D);
  localparam int BIT_W  = 4;

  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(D - 1);

  if (D < 2) begin : g_div_check
    $error("serial_output_fifo: clock_frequency / baud_rate must be at least 2");
  end
  if ((data_bits < 5) || (data_bits > 9)) begin : g_bits_check
    $error("serial_output_fifo: data_bits must be 5..9");
  end
  if ((parity < 0) || (parity > 2)) begin : g_par_check
    $error("serial_output_fifo: parity must be 0, 1 or 2");
  end
  if ((stop_bits < 1) || (stop_bits > 2)) begin : g_stop_check
    $error("serial_output_fifo: stop_bits must be 1 or 2");
  end

  // CTS synchroniser
  logic cts_m;
  logic cts_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_m <= 1'b0;
      cts_s <= 1'b0;
    end else begin
      cts_m <= cts;
      cts_s <= cts_m;
    end
  end

  // Word buffer
  logic [data_bits-1:0] head;
  logic                 head_valid;
  logic                 pop;

  sync_fifo #(
    .WIDTH (data_bits),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tdata   (in1),
    .in_tvalid  (in1_stb),
    .in_tready  (in1_ack),
    .out_tdata  (head),
    .out_tvalid (head_valid),
    .out_tready (pop),
    .count      (fill_level)
  );

  // Transmitter state
  tx_state_t            state,    state_next;
  logic [BAUD_W-1:0]    baud_cnt, baud_next;
  logic [BIT_W-1:0]     bit_cnt,  bit_next;
  logic                 stop_cnt, stop_next;
  logic [data_bits-1:0] shift_reg, shift_next;
  logic                 par_bit,  par_next;
  logic                 tx_next;
  logic                 baud_done;

  assign baud_done = (baud_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_cnt   <= bit_next;
      stop_cnt  <= stop_next;
      shift_reg <= shift_next;
      par_bit   <= par_next;
      tx        <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    stop_next  = stop_cnt;
    shift_next = shift_reg;
    par_next   = par_bit;
    tx_next    = tx;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        // CTS only gates the start of a frame; a frame once begun always completes.
        if (head_valid && cts_s) begin
          pop        = 1'b1;
          shift_next = head;
          par_next   = (^head) ^ (parity == PARITY_ODD);
          baud_next  = BAUD_LOAD;
          tx_next    = 1'b0;
          state_next = START;
        end
      end

      START: begin
        if (baud_done) begin
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
          bit_next   = BIT_W'(data_bits - 1);
          baud_next  = BAUD_LOAD;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt - BAUD_W'(1);
        end
      end

      DATA: begin
        // bit_cnt holds the number of data bits still to go after the one on the line.
        if (baud_done) begin
          baud_next = BAUD_LOAD;
          if (bit_cnt == '0) begin
            if (parity != PARITY_NONE) begin
              tx_next    = par_bit;
              state_next = PARITY;
            end else begin
              tx_next    = 1'b1;
              stop_next  = 1'(stop_bits - 1);
              state_next = STOP;
            end
          end else begin
            tx_next    = shift_reg[0];
            shift_next = shift_reg >> 1;
            bit_next   = bit_cnt - BIT_W'(1);
          end
        end else begin
          baud_next = baud_cnt - BAUD_W'(1);
        end
      end

      PARITY: begin
        if (baud_done) begin
          tx_next    = 1'b1;
          stop_next  = 1'(stop_bits - 1);
          baud_next  = BAUD_LOAD;
          state_next = STOP;
        end else begin
          baud_next = baud_cnt - BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_done) begin
          if (stop_cnt == 1'b0) begin
            state_next = IDLE;
          end else begin
            stop_next = 1'b0;
            baud_next = BAUD_LOAD;
          end
        end else begin
          baud_next = baud_cnt - BAUD_W'(1);
        end
      end

      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE) || (fill_level != '0);

endmodule

// File: tb/tb_serial_output_fifo.sv
// tb/tb_serial_output_fifo.sv - directed self-checking bench for serial_output_fifo
// Instances:
//   u_a : D=25, 8N1, depth 4  (basic frame, FIFO full, CTS, reset)
//   u_b : D=25, 8E2, depth 16
//   u_c : D=4,  9N1, depth 16
//   u_d : D=25, 8O1, depth 16

module tb_serial_output_fifo;

  logic       clk;
  logic       rst_n;
  logic [8:0] in1_w;
  logic       stb_v  [4];
  logic       cts_v  [4];
  logic       ack_v  [4];
  logic       tx_v   [4];
  logic       busy_v [4];
  logic [2:0] fill_a;
  logic [4:0] fill_b;
  logic [4:0] fill_c;
  logic [4:0] fill_d;

  int dv [4] = '{25, 25, 4, 25};
  int tests = 0;
  int fails = 0;
  int cycle = 0;

  serial_output_fifo #(
    .clock_frequency(50000000), .baud_rate(2000000), .data_bits(8),
    .parity(0), .stop_bits(1), .fifo_depth(4)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .in1(in1_w[7:0]), .in1_stb(stb_v[0]), .in1_ack(ack_v[0]),
    .cts(cts_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .fill_level(fill_a)
  );

  serial_output_fifo #(
    .clock_frequency(50000000), .baud_rate(2000000), .data_bits(8),
    .parity(2), .stop_bits(2), .fifo_depth(16)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .in1(in1_w[7:0]), .in1_stb(stb_v[1]), .in1_ack(ack_v[1]),
    .cts(cts_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .fill_level(fill_b)
  );

  serial_output_fifo #(
    .clock_frequency(8), .baud_rate(2), .data_bits(9),
    .parity(0), .stop_bits(1), .fifo_depth(16)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .in1(in1_w), .in1_stb(stb_v[2]), .in1_ack(ack_v[2]),
    .cts(cts_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .fill_level(fill_c)
  );

  serial_output_fifo #(
    .clock_frequency(50000000), .baud_rate(2000000), .data_bits(8),
    .parity(1), .stop_bits(1), .fifo_depth(16)
  ) u_d (
    .clk(clk), .rst_n(rst_n), .in1(in1_w[7:0]), .in1_stb(stb_v[3]), .in1_ack(ack_v[3]),
    .cts(cts_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .fill_level(fill_d)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one word and hold stb until it is accepted; returns on the negedge after transfer.
  task automatic push(input int idx, input logic [8:0] w);
    int n;
    n = 0;
    in1_w = w;
    stb_v[idx] = 1'b1;
    while (ack_v[idx] !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("push_timeout", 0, 1);
    @(negedge clk);
    stb_v[idx] = 1'b0;
  endtask

  // Wait for a start bit, then sample nb bit centres (start bit first). Ends at the last centre.
  task automatic get_frame(input int idx, input int nb, output logic [15:0] bits, output int t_fall);
    int n;
    n = 0;
    bits = '0;
    t_fall = 0;
    while (tx_v[idx] !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      check("frame_timeout", 0, 1);
      return;
    end
    t_fall = cycle;
    repeat (dv[idx] / 2) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      bits[i] = tx_v[idx];
      if (i < nb - 1) repeat (dv[idx]) @(negedge clk);
    end
  endtask

  logic [15:0] bits;
  int          t1, t2, lat, k, lows;
  logic        got5;
  logic [7:0]  words [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};

  initial begin
    rst_n = 1'b0;
    in1_w = '0;
    for (int i = 0; i < 4; i++) begin
      stb_v[i] = 1'b0;
      cts_v[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("rst_tx",   tx_v[0],   1);
    check("rst_ack",  ack_v[0],  0);
    check("rst_busy", busy_v[0], 0);
    check("rst_fill", fill_a,    0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5, 8N1, D=25
    push(0, 9'h0A5);
    get_frame(0, 10, bits, t1);
    check("a5_8n1_frame", bits, {1'b1, 8'hA5, 1'b0});
    repeat (12) @(negedge clk);
    check("a5_busy_last_cycle", busy_v[0], 1);
    @(negedge clk);
    check("a5_busy_done", busy_v[0], 0);

    // 0xA5, 8E2: even parity 0, two stop bits
    push(1, 9'h0A5);
    get_frame(1, 12, bits, t1);
    check("a5_8e2_frame", bits, {2'b11, 1'b0, 8'hA5, 1'b0});
    check("a5_8e2_busy_in_stop2", busy_v[1], 1);
    repeat (13) @(negedge clk);
    check("a5_8e2_busy_done", busy_v[1], 0);

    // 0xA5, 8O1: odd parity 1
    push(3, 9'h0A5);
    get_frame(3, 11, bits, t1);
    check("a5_8o1_frame", bits, {1'b1, 1'b1, 8'hA5, 1'b0});

    // 0x1FF, 9N1, D=4, back to back: 44-cycle frame plus one idle cycle
    push(2, 9'h1FF);
    push(2, 9'h1FF);
    get_frame(2, 11, bits, t1);
    check("9n1_frame1", bits, {1'b1, 9'h1FF, 1'b0});
    get_frame(2, 11, bits, t2);
    check("9n1_frame2", bits, {1'b1, 9'h1FF, 1'b0});
    check("9n1_period", t2 - t1, 45);
    repeat (10) @(negedge clk);
    check("9n1_fill_end", fill_c, 0);
    check("8e2_fill_end", fill_b, 0);
    check("8o1_fill_end", fill_d, 0);

    // FIFO full with CTS low: 4 of 5 accepted, line stays idle
    cts_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (k < 5) begin
        in1_w = {1'b0, words[k]};
        stb_v[0] = 1'b1;
        if (ack_v[0] === 1'b1) k++;
      end
    end
    check("full_accepted", k, 4);
    check("full_ack", ack_v[0], 0);
    check("full_fill", fill_a, 4);
    check("full_tx_idle", tx_v[0], 1);

    cts_v[0] = 1'b1;
    got5 = 1'b0;
    lat = 0;
    fork
      begin
        while (tx_v[0] !== 1'b0 && lat < 10) begin
          @(negedge clk);
          lat++;
        end
        check("cts_latency", (lat >= 2 && lat <= 3), 1);
        for (int f = 0; f < 5; f++) begin
          get_frame(0, 10, bits, t1);
          check("fifo_order", bits, {1'b1, words[f], 1'b0});
        end
      end
      begin
        for (int n = 0; n < 600; n++) begin
          if (ack_v[0] === 1'b1) begin
            @(negedge clk);
            stb_v[0] = 1'b0;
            got5 = 1'b1;
            break;
          end
          @(negedge clk);
        end
        stb_v[0] = 1'b0;
      end
    join
    check("fifo_5th_accepted", got5, 1);
    check("fifo_drained", fill_a, 0);
    repeat (20) @(negedge clk);

    // CTS drop mid-frame: word 1 completes, word 2 waits
    push(0, 9'h03C);
    push(0, 9'h0C3);
    fork
      get_frame(0, 10, bits, t1);
      begin
        repeat (75) @(negedge clk);
        cts_v[0] = 1'b0;
      end
    join
    check("cts_drop_frame1", bits, {1'b1, 8'h3C, 1'b0});
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_v[0] === 1'b0) lows++;
    end
    check("cts_hold_line", lows, 0);
    check("cts_hold_fill", fill_a, 1);
    check("cts_hold_busy", busy_v[0], 1);
    cts_v[0] = 1'b1;
    get_frame(0, 10, bits, t1);
    check("cts_resume_frame2", bits, {1'b1, 8'hC3, 1'b0});
    repeat (20) @(negedge clk);

    // Asynchronous reset in the middle of a frame
    push(0, 9'h055);
    push(0, 9'h066);
    repeat (40) @(negedge clk);
    check("pre_rst_busy", busy_v[0], 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_tx",   tx_v[0],   1);
    check("mid_rst_fill", fill_a,    0);
    check("mid_rst_ack",  ack_v[0],  0);
    check("mid_rst_busy", busy_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_ack_before_edge", ack_v[0], 0);
    @(negedge clk);
    check("rel_ack_after_edge", ack_v[0], 1);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_v[0] === 1'b0) lows++;
    end
    check("rel_no_residual", lows, 0);
    check("rel_fill", fill_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
